// File: rtl/v1_shift_queue_ctrl.sv
// ---------------------------------------------------------------------------
// v1_shift_queue_ctrl
//
// Control path for a shift-register queue. The storage entries live outside
// this block; the controller tells each entry whether to load the broadcast
// enqueue data (wr_data) or to take the value of its upstream neighbour
// (shift_en, entry i loads entry i+1). Entry 0 is always the head.
//
// The only state held here is the occupancy counter. Every other output is a
// combinational function of that counter, enq_val, deq_rdy and rst.
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   synchronous active-high reset; empties the queue
//   enq_val     in   producer offers enq_msg
//   enq_rdy     out  a message can be accepted this cycle (not full)
//   enq_msg     in   incoming message, p_bitwidth bits
//   deq_val     out  head entry holds a valid message (not empty)
//   deq_rdy     in   consumer takes the head this cycle
//   wr_data     out  per-entry write strobe, one-hot or zero
//   wr_data_in  out  write data broadcast to every entry (= enq_msg)
//   shift_en    out  per-entry shift strobe, entry i loads entry i+1
//   count       out  current occupancy, 0..p_depth
//   full        out  count == p_depth
//   empty       out  count == 0
// ---------------------------------------------------------------------------
module v1_shift_queue_ctrl #(
  parameter int p_depth    = 4,
  parameter int p_bitwidth = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enq_val,
  output logic                           enq_rdy,
  input  logic [p_bitwidth-1:0]          enq_msg,
  output logic                           deq_val,
  input  logic                           deq_rdy,
  output logic [p_depth-1:0]             wr_data,
  output logic [p_bitwidth-1:0]          wr_data_in,
  output logic [p_depth-1:0]             shift_en,
  output logic [$clog2(p_depth+1)-1:0]   count,
  output logic                           full,
  output logic                           empty
);

  localparam int CW = $clog2(p_depth + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(p_depth);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          enq_fire;
  logic          deq_fire;
  logic [CW-1:0] wr_idx;

  // Occupancy register; reset wins over any concurrent fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign enq_rdy = !full;
  assign deq_val = !empty;
  assign count   = count_q;

  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_val & deq_rdy;

  assign wr_data_in = enq_msg;

  // Because enq_rdy/deq_val already block enqueue-on-full and
  // dequeue-on-empty, count can neither overflow nor underflow here.
  always_comb begin
    count_d = count_q;
    if (enq_fire && !deq_fire) begin
      count_d = count_q + CW'(1);
    end else if (deq_fire && !enq_fire) begin
      count_d = count_q - CW'(1);
    end
  end

  // On a simultaneous enqueue/dequeue the tail moves down one slot while the
  // new message lands in the slot the old tail vacates (count-1). The write
  // strobe overrides the shift for that entry inside the storage.
  always_comb begin
    wr_idx = count_q;
    if (deq_fire) begin
      wr_idx = count_q - CW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < p_depth; gi++) begin : g_strobe
      localparam logic [CW-1:0] IDX_C  = CW'(gi);
      localparam logic [CW-1:0] NEXT_C = CW'(gi + 1);

      // Entry gi loads from entry gi+1 only when gi+1 is still occupied,
      // so entries at or beyond count never shift.
      assign shift_en[gi] = !rst && deq_fire && (NEXT_C < count_q);
      assign wr_data[gi]  = !rst && enq_fire && (wr_idx == IDX_C);
    end
  endgenerate

endmodule
